// File: rtl/somador_serial_pkg.sv
// somador_serial_pkg: typed FSM state for the bit-serial adder.
// Encodings come from somador_serial_defs.vh so other code can share the same values.
package somador_serial_pkg;

`include "somador_serial_defs.vh"

  typedef enum logic [1:0] {
    StOcioso = `SOMADOR_OCIOSO,
    StSoma   = `SOMADOR_SOMA,
    StFim    = `SOMADOR_FIM
  } state_e;

endpackage

// File: rtl/somador_serial_defs.vh
// State encodings shared by the serial adder FSM and anything that decodes its state.
`ifndef SOMADOR_SERIAL_DEFS_VH
`define SOMADOR_SERIAL_DEFS_VH

`define SOMADOR_OCIOSO 2'd0
`define SOMADOR_SOMA   2'd1
`define SOMADOR_FIM    2'd2

`endif

// File: rtl/somadorcompleto.sv
// somadorcompleto: structural 1-bit full adder.
// Ports: x, y, ci (inputs); sum, co (outputs).
module somadorcompleto (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic xy_x;
  logic xy_a;
  logic cx_a;

  xor g_x1 (xy_x, x, y);
  xor g_x2 (sum, xy_x, ci);
  and g_a1 (xy_a, x, y);
  and g_a2 (cx_a, xy_x, ci);
  or  g_o1 (co, xy_a, cx_a);

endmodule

// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder, {cout,s} = a + b + cin, LSB first, one bit per clock
// through a single full adder.
// Ports: clk, rst (sync, active-high), start, a, b, cin (inputs);
//        busy, done (one-cycle pulse), s, cout (registered result) (outputs).
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e state_q, state_d;

  logic [N-1:0]  a_q, b_q, res_q, s_q;
  logic          carry_q, cout_q, done_q;
  logic [CW-1:0] cnt_q;
  logic          sum_bit, carry_bit;
  logic          last_bit;

  assign last_bit = (cnt_q == CW'(N - 1));

  somadorcompleto u_fa (
    .x   (a_q[0]),
    .y   (b_q[0]),
    .ci  (carry_q),
    .sum (sum_bit),
    .co  (carry_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOcioso;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOcioso: if (start)    state_d = StSoma;
      StSoma:   if (last_bit) state_d = StFim;
      StFim:                  state_d = StOcioso;
      default:                state_d = StOcioso;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != StOcioso);
    done = done_q;
    s    = s_q;
    cout = cout_q;
  end

  // Datapath: operand shifters, carry, result shifter, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StOcioso: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        StSoma: begin
          // Sum bits enter at the MSB so after N shifts bit 0 sits at the LSB.
          res_q   <= {sum_bit, res_q[N-1:1]};
          carry_q <= carry_bit;
          a_q     <= {1'b0, a_q[N-1:1]};
          b_q     <= {1'b0, b_q[N-1:1]};
          cnt_q   <= cnt_q + CW'(1);
        end
        StFim: begin
          s_q    <= res_q;
          cout_q <= carry_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
module tb_somador_serial;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [N-1:0] s;

  int total = 0;
  int bad = 0;

  somador_serial #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Reference: plain (N+1)-bit addition.
  function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
  endfunction

  // Runs one operation starting from an idle DUT; reports latency in edges after the
  // accept edge, the result, done count and how often s moved before done.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc,
                       input bit hold_start, output int lat, output logic [N-1:0] rs,
                       output logic rc, output int dones, output int s_moves);
    logic [N-1:0] prev_s;
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    if (hold_start) begin
      a = 8'hAA; b = 8'hAA;
    end else begin
      start = 1'b0;
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    end
    prev_s = s; lat = -1; dones = 0; s_moves = 0; rs = 'x; rc = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i; dones++; rs = s; rc = cout;
        start = 1'b0;
        break;
      end
      if (s !== prev_s) s_moves++;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                          input logic tc, input bit hold_start);
    int lat, dones, s_moves;
    logic [N-1:0] rs;
    logic rc;
    logic [N:0] exp;
    exp = ref_add(ta, tb_, tc);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s idle_before: busy=%b want 0", name, busy);
    end
    do_op(ta, tb_, tc, hold_start, lat, rs, rc, dones, s_moves);
    total++;
    if (lat !== N + 1) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, N + 1);
    end
    total++;
    if ({rc, rs} !== exp) begin
      bad++; $display("FAIL %s result: got cout=%b s=%h want cout=%b s=%h",
                      name, rc, rs, exp[N], exp[N-1:0]);
    end
    total++;
    if (s_moves !== 0) begin
      bad++; $display("FAIL %s s_stable: s changed %0d times before done", name, s_moves);
    end
    // done must be a single pulse and the DUT must go idle without another accept
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++;
    if (dones !== 1 || busy !== 1'b0) begin
      bad++; $display("FAIL %s single_done: dones=%0d busy=%b want 1 and 0", name, dones, busy);
    end
    total++;
    if ({cout, s} !== exp) begin
      bad++; $display("FAIL %s hold: got cout=%b s=%h want cout=%b s=%h",
                      name, cout, s, exp[N], exp[N-1:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    total++;
    if ({busy, done, cout, s} !== '0) begin
      bad++; $display("FAIL reset: busy=%b done=%b cout=%b s=%h want all 0", busy, done, cout, s);
    end
  endtask

  task automatic test_directed();
    check_op("5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
    check_op("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    check_op("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    check_op("zero", 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_start_during_busy();
    check_op("hold_start", 8'h12, 8'h34, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int dones = 0;
    int busy_bad = 0;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // accept edge opens SOMA cycle 1; three more edges reach SOMA cycle 4
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy, cout, s} !== '0) begin
      bad++; $display("FAIL abort_clear: busy=%b cout=%b s=%h want 0", busy, cout, s);
    end
    for (int i = 0; i < N + 4; i++) begin
      if (done) dones++;
      if (busy) busy_bad++;
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 0 || busy_bad !== 0) begin
      bad++; $display("FAIL abort_no_done: dones=%0d busy_cycles=%0d want 0 and 0",
                      dones, busy_bad);
    end
    check_op("after_abort", 8'h80, 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      check_op("random", N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_during_busy();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
